ram_responder: RTL and testbench

Byte-addressed synchronous RAM that serves as the memory end of the datapath's MFA/MFC handshake. It accepts byte, halfword and word reads and writes, inserts a programmable number of wait states, and completes each access with a four-phase MFC acknowledge. It sits beside the datapath; the datapath drives MFA, RW_RAM, DataSize, the MAR address and the MDR write data, and captures DataOut on MFC.

---
 rtl/ram_pkg.sv | 34 +++
 rtl/ram_byte_array.sv | 39 +++
 rtl/ram_responder.sv | 194 +++++++++++++++++++
 tb/tb_ram_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the RAM responder.
//   - DataSize encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD)
//   - RW_RAM encodings (RW_READ, RW_WRITE)
//   - Responder FSM state enum (IDLE, WAIT, DONE)
//   - size_lane_mask(): byte lanes touched by an access of a given size
package ram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } ram_state_e;

    // Lane i carries the byte at (aligned address + i). The reserved
    // encoding behaves exactly like a word.
    function automatic logic [3:0] size_lane_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001;
            SZ_HALF: mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ram_byte_array.sv
// ram_byte_array: 2^ADDR_WIDTH x 8 byte storage with four independent lanes.
//   clk      in   write clock (rising edge)
//   rd_addr  in   per-lane read address (combinational read)
//   rd_data  out  per-lane read data
//   wr_en    in   per-lane write enable
//   wr_addr  in   per-lane write address
//   wr_data  in   per-lane write data
// Storage has no reset; contents survive rst_n. The responder always drives
// distinct addresses on the enabled lanes of one access.
module ram_byte_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic [3:0][ADDR_WIDTH-1:0] rd_addr,
    output logic [3:0][7:0]            rd_data,
    input  logic [3:0]                 wr_en,
    input  logic [3:0][ADDR_WIDTH-1:0] wr_addr,
    input  logic [3:0][7:0]            wr_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) begin
                mem[wr_addr[i]] <= wr_data[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd_data[i] = mem[rd_addr[i]];
        end
    end

endmodule

// File: rtl/ram_responder.sv
// ram_responder: byte-addressed RAM answering the datapath's MFA/MFC
// handshake with a programmable number of wait states.
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   MFA       in   request, held high until MFC is seen
//   RW_RAM    in   1 = read, 0 = write
//   DataSize  in   00 byte, 01 halfword, 10 word, 11 treated as word
//   Address   in   byte address, low ADDR_WIDTH bits used
//   DataIn    in   write data, low lanes used for byte/halfword
//   DataOut   out  zero-extended read data, valid while MFC = 1
//   MFC       out  access complete
//   state     out  current FSM state, for observation only
//
// Handshake: a request is taken when MFA is sampled high in IDLE. MFC rises
// WAIT_STATES+1 edges later and stays high until MFA is sampled low, which
// returns the FSM to IDLE. Dropping MFA before MFC rises aborts the access
// with no side effects.
module ram_responder
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MFA,
    input  logic        RW_RAM,
    input  logic [1:0]  DataSize,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output ram_state_e  state
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

    ram_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  capture;
    logic                  commit;

    logic                  req_rw_q;
    logic [1:0]            req_size_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [31:0]           req_data_q;
    logic [31:0]           data_out_q;

    logic [ADDR_WIDTH-1:0] addr_lo;
    logic [ADDR_WIDTH-1:0] addr_aligned;
    logic [3:0]            lane_mask;
    logic [31:0]           rd_word;

    logic [3:0][ADDR_WIDTH-1:0] lane_addr;
    logic [3:0][7:0]            lane_rd_data;
    logic [3:0][7:0]            lane_wr_data;
    logic [3:0]                 lane_wr_en;

    // Address bits above the RAM depth are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^Address[31:ADDR_WIDTH];

    // ------------------------------------------------------------------
    // Alignment of the incoming address, done before capture so the
    // captured address is already lane-0 aligned.
    // ------------------------------------------------------------------
    assign addr_lo = Address[ADDR_WIDTH-1:0];

    always_comb begin
        addr_aligned = addr_lo;
        case (DataSize)
            SZ_BYTE: addr_aligned = addr_lo;
            SZ_HALF: addr_aligned = {addr_lo[ADDR_WIDTH-1:1], 1'b0};
            default: addr_aligned = {addr_lo[ADDR_WIDTH-1:2], 2'b00};
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register and counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter is loaded with WAIT_STATES on capture and the access
    // completes on the edge that finds it at zero. That gives the
    // WAIT_STATES+1 edge latency from the capture edge, including a single
    // WAIT cycle when WAIT_STATES is zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MFA) begin
                    capture = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!MFA) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (!MFA) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture: fields are frozen for the whole access.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_rw_q   <= RW_READ;
            req_size_q <= SZ_BYTE;
            req_addr_q <= '0;
            req_data_q <= 32'd0;
        end else if (capture) begin
            req_rw_q   <= RW_RAM;
            req_size_q <= DataSize;
            req_addr_q <= addr_aligned;
            req_data_q <= DataIn;
        end
    end

    // ------------------------------------------------------------------
    // Lane steering: lane i addresses byte (aligned + i), little-endian.
    // ------------------------------------------------------------------
    assign lane_mask = size_lane_mask(req_size_q);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i]    = req_addr_q + ADDR_WIDTH'(i);
            lane_wr_data[i] = req_data_q[8*i +: 8];
            lane_wr_en[i]   = commit && (req_rw_q == RW_WRITE) && lane_mask[i];
        end
    end

    always_comb begin
        rd_word = 32'd0;
        for (int i = 0; i < 4; i++) begin
            rd_word[8*i +: 8] = lane_mask[i] ? lane_rd_data[i] : 8'h00;
        end
    end

    ram_byte_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .rd_addr (lane_addr),
        .rd_data (lane_rd_data),
        .wr_en   (lane_wr_en),
        .wr_addr (lane_addr),
        .wr_data (lane_wr_data)
    );

    // ------------------------------------------------------------------
    // DataOut loads on the same edge MFC rises, and only for reads.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= 32'd0;
        end else if (commit && (req_rw_q == RW_READ)) begin
            data_out_q <= rd_word;
        end
    end

    assign DataOut = data_out_q;
    assign MFC     = (state_q == DONE);
    assign state   = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder. Four instances with different
// WAIT_STATES share the clock and reset; each has its own request signals.
module tb_ram_responder;
    import ram_pkg::*;

    localparam int NDUT = 4;
    localparam int WS_TAB [NDUT] = '{0, 2, 3, 5};

    logic        clk;
    logic        rst_n;
    logic        mfa   [NDUT];
    logic        rw    [NDUT];
    logic [1:0]  size  [NDUT];
    logic [31:0] addr  [NDUT];
    logic [31:0] din   [NDUT];
    logic [31:0] dout  [NDUT];
    logic        mfc   [NDUT];
    ram_state_e  st    [NDUT];

    int checks;
    int errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ram_responder #(
            .ADDR_WIDTH  (8),
            .WAIT_STATES (WS_TAB[g])
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .MFA      (mfa[g]),
            .RW_RAM   (rw[g]),
            .DataSize (size[g]),
            .Address  (addr[g]),
            .DataIn   (din[g]),
            .DataOut  (dout[g]),
            .MFC      (mfc[g]),
            .state    (st[g])
        );
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One complete access on instance d. lat = edges from capture edge to
    // MFC high. hold = extra cycles MFA stays high after MFC. scramble
    // changes Address/DataIn right after capture.
    task automatic do_access(input int d, input logic rw_i, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int hold, input bit scramble,
                             output logic [31:0] rd, output int lat);
        int n;
        @(negedge clk);
        rw[d]   = rw_i;
        size[d] = sz;
        addr[d] = a;
        din[d]  = wd;
        mfa[d]  = 1'b1;
        @(posedge clk);
        #1;
        if (scramble) begin
            addr[d] = a ^ 32'h0000_0004;
            din[d]  = ~wd;
            size[d] = SZ_BYTE;
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!mfc[d] && n < 40);
        lat = n;
        if (!mfc[d]) check("mfc_timeout", 32'(mfc[d]), 32'd1);
        rd = dout[d];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("mfc_hold", 32'(mfc[d]), 32'd1);
            check("dout_hold", dout[d], rd);
        end
        mfa[d] = 1'b0;
        @(posedge clk);
        #1;
        check("mfc_fall", 32'(mfc[d]), 32'd0);
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int lat;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            mfa[i] = 1'b0; rw[i] = 1'b1; size[i] = 2'b00; addr[i] = '0; din[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check("rst_mfc", 32'(mfc[i]), 32'd0);
            check("rst_dout", dout[i], 32'd0);
            check("rst_state", 32'(st[i]), 32'(IDLE));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // ---- word write / reads on WAIT_STATES=2 (instance 1) ----
        do_access(1, RW_WRITE, SZ_WORD, 32'h10, 32'hDEADBEEF, 0, 0, rd, lat);
        check("lat_ws2_wr", 32'(lat), 32'd3);
        do_access(1, RW_READ, SZ_WORD, 32'h10, 32'h0, 0, 0, rd, lat);
        check("rd_word_10", rd, 32'hDEADBEEF);
        check("lat_ws2_rd", 32'(lat), 32'd3);
        do_access(1, RW_READ, SZ_BYTE, 32'h11, 32'h0, 0, 0, rd, lat);
        check("rd_byte_11", rd, 32'h000000BE);
        do_access(1, RW_READ, SZ_HALF, 32'h12, 32'h0, 0, 0, rd, lat);
        check("rd_half_12", rd, 32'h0000DEAD);
        do_access(1, RW_READ, SZ_HALF, 32'h13, 32'h0, 0, 0, rd, lat);
        check("rd_half_13", rd, 32'h0000DEAD);

        // ---- byte write, reserved-size read ----
        do_access(1, RW_WRITE, SZ_BYTE, 32'h12, 32'hAABBCC55, 0, 0, rd, lat);
        do_access(1, RW_READ, SZ_WORD, 32'h10, 32'h0, 0, 0, rd, lat);
        check("rd_after_bytewr", rd, 32'hDE55BEEF);
        do_access(1, RW_READ, SZ_RSVD, 32'h11, 32'h0, 0, 0, rd, lat);
        check("rd_rsvd_11", rd, 32'hDE55BEEF);

        // ---- latency sweep with 4-cycle hold ----
        do_access(0, RW_WRITE, SZ_HALF, 32'h31, 32'h0000A5C3, 4, 0, rd, lat);
        check("lat_ws0", 32'(lat), 32'd1);
        do_access(0, RW_READ, SZ_WORD, 32'h30, 32'h0, 0, 0, rd, lat);
        check("rd_ws0_half", rd & 32'h0000FFFF, 32'h0000A5C3);
        do_access(1, RW_READ, SZ_WORD, 32'h10, 32'h0, 4, 0, rd, lat);
        check("lat_ws2_hold", 32'(lat), 32'd3);
        do_access(3, RW_WRITE, SZ_WORD, 32'h44, 32'h00000000, 4, 0, rd, lat);
        check("lat_ws5", 32'(lat), 32'd6);

        // ---- input stability on WAIT_STATES=5 ----
        do_access(3, RW_WRITE, SZ_WORD, 32'h40, 32'h11223344, 0, 1, rd, lat);
        do_access(3, RW_READ, SZ_WORD, 32'h40, 32'h0, 0, 0, rd, lat);
        check("stable_rd_40", rd, 32'h11223344);
        do_access(3, RW_READ, SZ_WORD, 32'h44, 32'h0, 0, 0, rd, lat);
        check("stable_rd_44", rd, 32'h00000000);
        do_access(3, RW_READ, SZ_WORD, 32'h40, 32'h0, 0, 1, rd, lat);
        check("stable_rd_scr", rd, 32'h11223344);

        // ---- abort on WAIT_STATES=3 ----
        do_access(2, RW_WRITE, SZ_WORD, 32'h20, 32'hCAFEF00D, 0, 0, rd, lat);
        check("lat_ws3", 32'(lat), 32'd4);
        do_access(2, RW_READ, SZ_WORD, 32'h20, 32'h0, 0, 0, rd, lat);
        check("rd_20_pre", rd, 32'hCAFEF00D);
        @(negedge clk);
        rw[2] = RW_WRITE; size[2] = SZ_WORD; addr[2] = 32'h20; din[2] = 32'h12345678; mfa[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mfa[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("abort_mfc", 32'(mfc[2]), 32'd0);
        end
        check("abort_state", 32'(st[2]), 32'(IDLE));
        check("abort_dout", dout[2], 32'hCAFEF00D);
        do_access(2, RW_READ, SZ_WORD, 32'h20, 32'h0, 0, 0, rd, lat);
        check("rd_20_post", rd, 32'hCAFEF00D);

        // ---- asynchronous reset during WAIT (instance 1, in-flight write) ----
        @(negedge clk);
        rw[1] = RW_WRITE; size[1] = SZ_WORD; addr[1] = 32'h10; din[1] = 32'h0BADBEEF; mfa[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("pre_rst_state", 32'(st[1]), 32'(WAIT));
        check("pre_rst_dout", dout[1], 32'hDE55BEEF);
        rst_n = 1'b0;
        #1;
        check("async_rst_mfc", 32'(mfc[1]), 32'd0);
        check("async_rst_dout", dout[1], 32'd0);
        check("async_rst_state", 32'(st[1]), 32'(IDLE));
        mfa[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_access(1, RW_READ, SZ_WORD, 32'h10, 32'h0, 0, 0, rd, lat);
        check("post_rst_lat", 32'(lat), 32'd3);
        check("post_rst_rd", rd, 32'hDE55BEEF);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
